// File: rtl/gem_ext_fifo_pkg.sv
// Shared types and Ethernet framing constants for the GEM Tx frame path.
package gem_ext_fifo_pkg;

  typedef enum logic [1:0] {PASS, PAD, DROP} shaper_state_t;

  localparam int          ETH_MIN_LEN  = 60;
  localparam int          ETH_MAX_LEN  = 1514;
  localparam logic [7:0]  ETH_PAD_BYTE = 8'h00;

endpackage

// File: rtl/gem_tx_frame_shaper_if.sv
// Byte-wide AXI-Stream link with an error flag; master drives data, slave drives tready.
interface gem_tx_frame_shaper_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/gem_axis_out_reg.sv
// 1-deep AXIS register slice with a load-enable side; 1 cycle latency.
// Loadable when empty or draining this cycle; holds the beat stable while stalled.
module gem_axis_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  input  logic       ld_user,
  output logic       loadable,
  gem_tx_frame_shaper_if.master m_axis
);

  assign loadable = !m_axis.tvalid || m_axis.tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis.tvalid <= 1'b0;
      m_axis.tdata  <= 8'h00;
      m_axis.tlast  <= 1'b0;
      m_axis.tuser  <= 1'b0;
    end else if (ld && loadable) begin
      m_axis.tvalid <= 1'b1;
      m_axis.tdata  <= ld_data;
      m_axis.tlast  <= ld_last;
      m_axis.tuser  <= ld_user;
    end else if (m_axis.tready) begin
      m_axis.tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/gem_tx_frame_shaper.sv
// Pads runt frames to MIN_LEN, truncates past MAX_LEN (tuser=1); 1 cycle latency.
// Input is stalled while padding and free-flowing while discarding a truncated tail.
module gem_tx_frame_shaper
  import gem_ext_fifo_pkg::*;
#(
  parameter int         MIN_LEN  = ETH_MIN_LEN,
  parameter int         MAX_LEN  = ETH_MAX_LEN,
  parameter logic [7:0] PAD_BYTE = ETH_PAD_BYTE,
  parameter int         LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic clk,
  input  logic rst,
  gem_tx_frame_shaper_if.slave  s_axis,
  gem_tx_frame_shaper_if.master m_axis,
  output logic stat_frame,
  output logic stat_padded,
  output logic stat_truncated
);

  localparam logic [LEN_W-1:0] MIN_C = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_C = LEN_W'(MAX_LEN);

  shaper_state_t    state;
  logic [LEN_W-1:0] byte_cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic             err_acc;
  logic             loadable;
  logic             accept;
  logic             ld;
  logic [7:0]       ld_data;
  logic             ld_last;
  logic             ld_user;

  assign s_axis.tready = !rst && (state == DROP || (state == PASS && loadable));
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign cnt_inc       = byte_cnt + 1'b1;

  always_comb begin
    ld      = 1'b0;
    ld_data = s_axis.tdata;
    ld_last = 1'b0;
    ld_user = 1'b0;
    case (state)
      PASS: begin
        if (accept) begin
          ld = 1'b1;
          // An input tlast landing exactly on MAX_LEN is a normal end, so tlast is tested first.
          if (s_axis.tlast && cnt_inc >= MIN_C) begin
            ld_last = 1'b1;
            ld_user = err_acc | s_axis.tuser;
          end else if (!s_axis.tlast && cnt_inc == MAX_C) begin
            ld_last = 1'b1;
            ld_user = 1'b1;
          end
        end
      end
      PAD: begin
        if (loadable) begin
          ld      = 1'b1;
          ld_data = PAD_BYTE;
          if (cnt_inc == MIN_C) begin
            ld_last = 1'b1;
            ld_user = err_acc;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= PASS;
      byte_cnt       <= '0;
      err_acc        <= 1'b0;
      stat_frame     <= 1'b0;
      stat_padded    <= 1'b0;
      stat_truncated <= 1'b0;
    end else begin
      stat_frame     <= 1'b0;
      stat_padded    <= 1'b0;
      stat_truncated <= 1'b0;
      case (state)
        PASS: begin
          if (accept) begin
            if (ld_last) begin
              byte_cnt       <= '0;
              err_acc        <= 1'b0;
              stat_frame     <= 1'b1;
              stat_truncated <= !s_axis.tlast;
              state          <= s_axis.tlast ? PASS : DROP;
            end else begin
              byte_cnt <= cnt_inc;
              err_acc  <= err_acc | s_axis.tuser;
              if (s_axis.tlast) state <= PAD;
            end
          end
        end
        PAD: begin
          if (loadable) begin
            if (ld_last) begin
              byte_cnt    <= '0;
              err_acc     <= 1'b0;
              stat_frame  <= 1'b1;
              stat_padded <= 1'b1;
              state       <= PASS;
            end else begin
              byte_cnt <= cnt_inc;
            end
          end
        end
        DROP: begin
          if (accept && s_axis.tlast) state <= PASS;
        end
        default: state <= PASS;
      endcase
    end
  end

  gem_axis_out_reg u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_user  (ld_user),
    .loadable (loadable),
    .m_axis   (m_axis)
  );

endmodule
